// File: rtl/issue_ctrl_pkg.sv
// Shared constants for the instruction queue / dispatch block: optype codes,
// dispatch unit select, queue entry layout and the optype-to-unit routing rule.
package issue_ctrl_pkg;

    localparam int IQ_SIZE_LOG_DEF = 4;

    localparam logic [3:0] OP_CAL  = 4'd1;
    localparam logic [3:0] OP_CALI = 4'd2;
    localparam logic [3:0] OP_STR  = 4'd3;
    localparam logic [3:0] OP_LAD  = 4'd4;
    localparam logic [3:0] OP_BRA  = 4'd5;
    localparam logic [3:0] OP_JUM  = 4'd6;

    typedef enum logic {
        UNIT_RS  = 1'b0,
        UNIT_LSB = 1'b1
    } unit_e;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
    } iq_entry_t;

    // Memory ops go to the LSB; everything else, including unknown codes, to the RS.
    function automatic unit_e route_unit(input logic [3:0] optype);
        return (optype == OP_LAD || optype == OP_STR) ? UNIT_LSB : UNIT_RS;
    endfunction

endpackage

// File: rtl/issue_ctrl_fifo.sv
// Circular {ins, pc} buffer with head/tail/count; push/pop/clr arrive pre-qualified.
module issue_ctrl_fifo
    import issue_ctrl_pkg::*;
#(
    parameter int LOG = IQ_SIZE_LOG_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            clr,
    input  iq_entry_t       wr_data,
    output iq_entry_t       rd_data,
    output logic [LOG:0]    count
);

    localparam int DEPTH = 1 << LOG;

    iq_entry_t          mem_q [DEPTH];
    logic [LOG-1:0]     head_q, head_d;
    logic [LOG-1:0]     tail_q, tail_d;
    logic [LOG:0]       count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clr) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop)  head_d = head_q + 1'b1;
            if (push) tail_d = tail_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // On a full queue with a simultaneous pop, tail == head: the popped slot is
    // read combinationally before the edge overwrites it.
    always_ff @(posedge clk) begin
        if (push && !clr) mem_q[tail_q] <= wr_data;
    end

    assign rd_data = mem_q[head_q];
    assign count   = count_q;

endmodule

// File: rtl/issue_ctrl.sv
// Instruction queue front end: buffers fetched instructions and dispatches the
// head to RS or LSB, allocating a ROB entry, when downstream has room.
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int IQ_SIZE_LOG = IQ_SIZE_LOG_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clr_in,
    input  logic        if_valid_in,
    input  logic [31:0] if_ins_in,
    input  logic [31:0] if_pc_in,
    output logic        iq_full_out,
    output logic        dec_ins_flg_out,
    output logic [31:0] dec_ins_out,
    output logic [31:0] dec_pc_out,
    input  logic [3:0]  dec_optype_in,
    input  logic        rob_full_in,
    input  logic        rs_full_in,
    input  logic        lsb_full_in,
    output logic        rob_add_out,
    output logic        rs_add_out,
    output logic        lsb_add_out,
    output logic [31:0] issued_cnt_out
);

    localparam int                 DEPTH   = 1 << IQ_SIZE_LOG;
    localparam logic [IQ_SIZE_LOG:0] DEPTH_C = DEPTH[IQ_SIZE_LOG:0];
    localparam logic [IQ_SIZE_LOG:0] FULL_C  = DEPTH_C - 1'b1;

    iq_entry_t              head_e;
    iq_entry_t              wr_e;
    logic [IQ_SIZE_LOG:0]   count;
    logic                   head_vld, to_lsb, unit_full, go, push, clr_en;
    logic [31:0]            issued_cnt_q, issued_cnt_d;

    assign wr_e = '{ins: if_ins_in, pc: if_pc_in};

    issue_ctrl_fifo #(.LOG(IQ_SIZE_LOG)) u_fifo (
        .clk     (clk_in),
        .rst     (rst_in),
        .push    (push),
        .pop     (go),
        .clr     (clr_en),
        .wr_data (wr_e),
        .rd_data (head_e),
        .count   (count)
    );

    always_comb begin
        head_vld     = (count != '0) && !clr_in;
        to_lsb       = (route_unit(dec_optype_in) == UNIT_LSB);
        unit_full    = to_lsb ? lsb_full_in : rs_full_in;
        go           = head_vld && rdy_in && !rob_full_in && !unit_full;
        // A full queue still accepts when the head leaves in the same cycle.
        push         = if_valid_in && rdy_in && !clr_in && ((count < DEPTH_C) || go);
        clr_en       = clr_in && rdy_in;
        issued_cnt_d = issued_cnt_q + {31'd0, go};
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) issued_cnt_q <= '0;
        else        issued_cnt_q <= issued_cnt_d;
    end

    // Asserting one entry early leaves the fetcher a cycle of in-flight slack.
    assign iq_full_out     = (count >= FULL_C);
    assign dec_ins_flg_out = head_vld;
    assign dec_ins_out     = head_e.ins;
    assign dec_pc_out      = head_e.pc;
    assign rob_add_out     = go;
    assign rs_add_out      = go && !to_lsb;
    assign lsb_add_out     = go && to_lsb;
    assign issued_cnt_out  = issued_cnt_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed scenarios plus randomized traffic, all checked
// against a queue-based reference model of the dispatch rules.
module tb_issue_ctrl;
    import issue_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, clr, if_valid;
    logic [31:0] if_ins, if_pc;
    logic [3:0]  optype;
    logic        rob_full, rs_full, lsb_full;
    logic        iq_full, flg, rob_add, rs_add, lsb_add;
    logic [31:0] dec_ins, dec_pc, issued;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] mq[$];
    logic [31:0] missued = 0;

    always #5 clk = ~clk;

    issue_ctrl dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clr_in(clr),
        .if_valid_in(if_valid), .if_ins_in(if_ins), .if_pc_in(if_pc),
        .iq_full_out(iq_full), .dec_ins_flg_out(flg),
        .dec_ins_out(dec_ins), .dec_pc_out(dec_pc),
        .dec_optype_in(optype), .rob_full_in(rob_full),
        .rs_full_in(rs_full), .lsb_full_in(lsb_full),
        .rob_add_out(rob_add), .rs_add_out(rs_add), .lsb_add_out(lsb_add),
        .issued_cnt_out(issued)
    );

    function automatic bit m_to_lsb(input logic [3:0] op);
        return (op == OP_LAD) || (op == OP_STR);
    endfunction

    function automatic bit m_go();
        if (mq.size() == 0 || clr || !rdy || rob_full) return 1'b0;
        return m_to_lsb(optype) ? !lsb_full : !rs_full;
    endfunction

    task automatic idle();
        rdy = 1; clr = 0; if_valid = 0; if_ins = 0; if_pc = 0;
        optype = OP_CAL; rob_full = 0; rs_full = 0; lsb_full = 0;
    endtask

    // Advance one clock edge and apply the same edge to the reference model.
    task automatic tick();
        bit g, p;
        logic [63:0] dummy;
        g = m_go();
        p = if_valid && rdy && !clr && (mq.size() < 16 || g);
        @(posedge clk);
        if (!rst) begin
            if (rdy && clr) mq.delete();
            else begin
                if (g) begin dummy = mq.pop_front(); missued++; end
                if (p) mq.push_back({if_ins, if_pc});
            end
        end
        #1;
    endtask

    task automatic push_one(input logic [31:0] ins, input logic [31:0] pc);
        if_valid = 1; if_ins = ins; if_pc = pc;
        tick();
        if_valid = 0;
    endtask

    task automatic test_reset();
        idle(); rst = 1; if_valid = 1; if_pc = 32'h55;
        repeat (2) @(posedge clk);
        #2;
        n_checks++; if (flg !== 1'b0) begin n_fail++; $display("FAIL reset_flg: got %b expected 0", flg); end
        n_checks++; if (iq_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", iq_full); end
        n_checks++; if ({rob_add, rs_add, lsb_add} !== 3'b000) begin n_fail++; $display("FAIL reset_adds: got %b expected 000", {rob_add, rs_add, lsb_add}); end
        n_checks++; if (issued !== 32'd0) begin n_fail++; $display("FAIL reset_issued: got %0d expected 0", issued); end
        rst = 0; idle();
        @(posedge clk); #1;
    endtask

    task automatic test_single_cal();
        idle(); optype = OP_CAL;
        push_one(32'h003100B3, 32'h0);
        #1;
        n_checks++; if (flg !== 1'b1) begin n_fail++; $display("FAIL cal_flg: got %b expected 1", flg); end
        n_checks++; if (dec_ins !== 32'h003100B3) begin n_fail++; $display("FAIL cal_ins: got %h expected 003100b3", dec_ins); end
        n_checks++; if ({rob_add, rs_add, lsb_add} !== 3'b110) begin n_fail++; $display("FAIL cal_adds: got %b expected 110", {rob_add, rs_add, lsb_add}); end
        tick();
        n_checks++; if (issued !== 32'd1) begin n_fail++; $display("FAIL cal_issued: got %0d expected 1", issued); end
        n_checks++; if (flg !== 1'b0) begin n_fail++; $display("FAIL cal_empty: got %b expected 0", flg); end
    endtask

    task automatic test_lsb_stall();
        idle(); optype = OP_LAD; lsb_full = 1;
        push_one(32'h0000A083, 32'h4);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if ({rob_add, rs_add, lsb_add} !== 3'b000 || flg !== 1'b1 || dec_pc !== 32'h4)
                begin n_fail++; $display("FAIL lsb_stall: got adds=%b flg=%b pc=%h expected 000/1/4", {rob_add, rs_add, lsb_add}, flg, dec_pc); end
            tick();
        end
        lsb_full = 0; #1;
        n_checks++; if ({rob_add, rs_add, lsb_add} !== 3'b101) begin n_fail++; $display("FAIL lsb_go: got %b expected 101", {rob_add, rs_add, lsb_add}); end
        tick();
        n_checks++; if (issued !== 32'd2) begin n_fail++; $display("FAIL lsb_issued: got %0d expected 2", issued); end
    endtask

    task automatic test_fill();
        idle(); rob_full = 1;
        for (int i = 0; i < 15; i++) begin
            push_one(32'h13 + i, 32'(i * 4));
            #1;
            n_checks++; if (iq_full !== (i >= 14)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b expected %b", i, iq_full, (i >= 14)); end
        end
        push_one(32'h13 + 15, 32'h3C);
        push_one(32'hDEAD, 32'h40);
        rob_full = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            n_checks++; if (rob_add !== 1'b1 || dec_pc !== 32'(i * 4))
                begin n_fail++; $display("FAIL fill_order[%0d]: got pc=%h rob=%b expected pc=%h rob=1", i, dec_pc, rob_add, i * 4); end
            tick();
        end
        n_checks++; if (flg !== 1'b0) begin n_fail++; $display("FAIL fill_drop: got flg=%b pc=%h expected empty", flg, dec_pc); end
        n_checks++; if (issued !== 32'd18) begin n_fail++; $display("FAIL fill_issued: got %0d expected 18", issued); end
    endtask

    task automatic test_clear();
        idle(); rob_full = 1;
        for (int i = 0; i < 5; i++) push_one(32'h100 + i, 32'h80 + 32'(i * 4));
        rob_full = 0; clr = 1; if_valid = 1; if_pc = 32'h999; #1;
        n_checks++; if ({flg, rob_add, rs_add, lsb_add} !== 4'b0000) begin n_fail++; $display("FAIL clr_same: got %b expected 0000", {flg, rob_add, rs_add, lsb_add}); end
        tick();
        clr = 0; if_valid = 0; #1;
        n_checks++; if (flg !== 1'b0 || rob_add !== 1'b0) begin n_fail++; $display("FAIL clr_after: got flg=%b rob=%b expected 0/0", flg, rob_add); end
        n_checks++; if (issued !== 32'd18) begin n_fail++; $display("FAIL clr_issued: got %0d expected 18", issued); end
    endtask

    task automatic test_wrap_full();
        idle(); rob_full = 1;
        for (int i = 0; i < 16; i++) push_one(32'h7000 + i, 32'h200 + 32'(i * 4));
        rob_full = 0; if_valid = 1; if_ins = 32'h7777; if_pc = 32'h300; #1;
        n_checks++; if (rob_add !== 1'b1 || dec_pc !== 32'h200) begin n_fail++; $display("FAIL wrap_go: got rob=%b pc=%h expected 1/200", rob_add, dec_pc); end
        tick();
        if_valid = 0; rob_full = 1; #1;
        n_checks++; if (iq_full !== 1'b1 || dec_pc !== 32'h204) begin n_fail++; $display("FAIL wrap_cnt: got full=%b pc=%h expected 1/204", iq_full, dec_pc); end
        rob_full = 0;
        for (int i = 0; i < 16; i++) begin
            logic [31:0] ep;
            ep = (i < 15) ? 32'h204 + 32'(i * 4) : 32'h300;
            #1;
            n_checks++; if (rob_add !== 1'b1 || dec_pc !== ep) begin n_fail++; $display("FAIL wrap_order[%0d]: got pc=%h expected %h", i, dec_pc, ep); end
            tick();
        end
        n_checks++; if (flg !== 1'b0) begin n_fail++; $display("FAIL wrap_empty: got %b expected 0", flg); end
    endtask

    task automatic test_rst_mid();
        idle(); rob_full = 1;
        for (int i = 0; i < 3; i++) push_one(32'h500 + i, 32'h400 + 32'(i * 4));
        rob_full = 0; #1;
        n_checks++; if (rob_add !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got %b expected 1", rob_add); end
        #2 rst = 1;
        #1;
        n_checks++; if ({flg, rob_add, rs_add, lsb_add, iq_full} !== 5'b0 || issued !== 32'd0)
            begin n_fail++; $display("FAIL rstmid_async: got outs=%b issued=%0d expected 0/0", {flg, rob_add, rs_add, lsb_add, iq_full}, issued); end
        mq.delete(); missued = 0;
        @(posedge clk); #1;
        rst = 0;
        push_one(32'h0000_0013, 32'h100);
        #1;
        n_checks++; if (flg !== 1'b1 || dec_pc !== 32'h100 || rob_add !== 1'b1) begin n_fail++; $display("FAIL rstmid_first: got flg=%b pc=%h rob=%b expected 1/100/1", flg, dec_pc, rob_add); end
        tick();
        n_checks++; if (issued !== 32'd1) begin n_fail++; $display("FAIL rstmid_issued: got %0d expected 1", issued); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            bit eg, el;
            rdy      = ($urandom_range(0, 9) != 0);
            clr      = ($urandom_range(0, 39) == 0);
            if_valid = $urandom_range(0, 1);
            if_ins   = $urandom;
            if_pc    = $urandom;
            optype   = 4'($urandom_range(0, 15));
            rob_full = ($urandom_range(0, 2) == 0);
            rs_full  = ($urandom_range(0, 3) == 0);
            lsb_full = ($urandom_range(0, 3) == 0);
            #1;
            eg = m_go(); el = m_to_lsb(optype);
            n_checks++; if (flg !== (mq.size() != 0 && !clr)) begin n_fail++; $display("FAIL rnd_flg[%0d]: got %b expected %b", c, flg, (mq.size() != 0 && !clr)); end
            n_checks++; if (iq_full !== (mq.size() >= 15)) begin n_fail++; $display("FAIL rnd_full[%0d]: got %b expected %b", c, iq_full, (mq.size() >= 15)); end
            n_checks++; if ({rob_add, rs_add, lsb_add} !== {eg, eg && !el, eg && el})
                begin n_fail++; $display("FAIL rnd_adds[%0d]: got %b expected %b", c, {rob_add, rs_add, lsb_add}, {eg, eg && !el, eg && el}); end
            n_checks++; if (issued !== missued) begin n_fail++; $display("FAIL rnd_issued[%0d]: got %0d expected %0d", c, issued, missued); end
            if (mq.size() != 0) begin
                n_checks++; if ({dec_ins, dec_pc} !== mq[0]) begin n_fail++; $display("FAIL rnd_head[%0d]: got %h expected %h", c, {dec_ins, dec_pc}, mq[0]); end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_cal();
        test_lsb_stall();
        test_fill();
        test_clear();
        test_wrap_full();
        test_rst_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- Instruction queue plus dispatch scheduler between the fetcher and the issue decoder.
- Buffers fetched {ins, pc} pairs in a circular FIFO and presents the head to the decoder.
- Uses the decoded optype to route the head to the reservation station (RS) or the load/store buffer (LSB), and allocates a ROB entry.
- Dispatches only when the ROB and the target unit have space. Flushes on mispredict clear.

Parameters:
- IQ_SIZE_LOG, 4, log2 of queue depth (DEPTH = 16 entries).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous reset, active-high
- rdy_in  input  1  global ready; low freezes all state
- clr_in  input  1  pipeline flush (mispredict)
- if_valid_in  input  1  fetcher delivers an instruction this cycle
- if_ins_in  input  32  fetched instruction word
- if_pc_in  input  32  pc of fetched instruction
- iq_full_out  output  1  back-pressure to fetcher
- dec_ins_flg_out  output  1  head valid, drives decoder ins_flg
- dec_ins_out  output  32  head instruction to decoder
- dec_pc_out  output  32  head pc to decoder
- dec_optype_in  input  4  decoder optype for the head
- rob_full_in  input  1  ROB cannot accept
- rs_full_in  input  1  RS cannot accept
- lsb_full_in  input  1  LSB cannot accept
- rob_add_out  output  1  allocate ROB entry for head
- rs_add_out  output  1  dispatch head to RS
- lsb_add_out  output  1  dispatch head to LSB
- issued_cnt_out  output  32  count of dispatched instructions

Behaviour:
- Storage: DEPTH entries of {ins, pc}.
  - head/tail are IQ_SIZE_LOG-bit pointers that wrap modulo DEPTH.
  - count is IQ_SIZE_LOG+1 bits, range 0..DEPTH.
- Reset (async, rst_in=1): head=tail=count=0, issued_cnt_out=0.
  - All outputs read 0 during reset: iq_full_out=0, dec_ins_flg_out=0, all add_out=0.
- dec_ins_flg_out = (count!=0) & ~clr_in. dec_ins_out/dec_pc_out = entry[head], combinational.
- Routing, combinational from dec_optype_in:
  - LAD or STR → LSB.
  - CAL, CALi, BRA, JUM → RS.
  - Any other value → RS.
- go = dec_ins_flg_out & rdy_in & ~rob_full_in & ~(to_lsb ? lsb_full_in : rs_full_in).
- When go is high:
  - rob_add_out=1, plus exactly one of rs_add_out/lsb_add_out =1, all in the same cycle.
  - head advances at the next edge.
- When go is low, all three add outputs are 0.
- Push: if_valid_in & rdy_in & ~clr_in & (count<DEPTH | go). Entry is written at tail, tail advances at the edge.
- Push when count==DEPTH and no go: the instruction is dropped. The fetcher must honour iq_full_out.
- iq_full_out = (count >= DEPTH-1), registered-count based. This gives one cycle of fetch-latency slack.
- Count update: +1 push only, -1 pop only, unchanged when both or neither.
- Latency: an instruction pushed at edge N is at head (if queue was empty) and can dispatch in cycle N+1. Minimum fetch-to-dispatch is 1 cycle.
- clr_in=1 at an edge (with rdy_in=1):
  - head=tail=count=0.
  - Same-cycle push and pop are discarded; no add outputs assert in that cycle.
  - issued_cnt_out is not cleared.
- rdy_in=0: no push, no pop, no clear; add outputs are 0; state held.
- issued_cnt_out increments by 1 at each edge where go=1, wraps at 2^32.
- Pointer wrap: entry 15 → head/tail 0 with no bubble.

Decomposition:
- Optype codes (CAL, CALi, STR, LAD, BRA, JUM) stay in the shared def.v constants file.
- Add IQ_SIZE_LOG default and a unit-select define (UNIT_RS, UNIT_LSB) to def.v.
- One natural sub-module: iq_fifo (circular {ins, pc} buffer with head/tail/count).
- issue_ctrl instantiates iq_fifo and holds the routing and dispatch logic.
- The existing decoder is instantiated beside it at top level, not inside it.

Test Plan:
- Push add x1,x2,x3 (0x003100B3, pc 0x0) with decoder optype=CAL, all fulls 0 → next cycle rob_add_out=1, rs_add_out=1, lsb_add_out=0, issued_cnt_out=1 after the edge.
- Push lw (0x0000A083, pc 0x4), lsb_full_in=1 for 3 cycles then 0 → no add outputs for 3 cycles, then rob_add_out=lsb_add_out=1 in one cycle. Count stays 1 during the stall.
- Hold rob_full_in=1, push 15 instructions → iq_full_out=1 once count=15. A 16th push is accepted (count=16); a 17th without pop is dropped. Release → 16 dispatches in order, pcs 0x0..0x3C.
- Queue holds 5 entries, assert clr_in with if_valid_in=1 → next cycle count=0, dec_ins_flg_out=0, no add outputs, issued_cnt_out unchanged.
- Queue at count=16 with go=1 and if_valid_in=1 same cycle → count stays 16, new entry written at wrapped tail, FIFO order preserved across the wrap.
- Assert rst_in mid-stream (asynchronously between edges) → outputs drop to 0 immediately. After release, a push of pc 0x100 dispatches first.
